eth_tx_arbiter: RTL and testbench
=================================

Name: eth_tx_arbiter

Overview:
- Two-requester packet scheduler in front of the byte-wide TX FIFO of the Ethernet MAC wrapper (ethernet_with_fifos).
- Grants the FIFO to one requester at a time using round-robin arbitration.
- For each packet it writes the 16-bit packet-size header the FIFO requires (MSB first), then streams the payload bytes, throttled by tx_full.
- Aborts cleanly on the FIFO's tx_reset; rejects illegal lengths without writing anything.

Parameters:
- MAX_LEN, 1514: largest legal payload length in bytes; longer requests are rejected.

Ports:
- clk_i  in  1  system clock; also the FIFO tx_clock domain
- rst_i  in  1  synchronous active-high reset
- req0_i  in  1  requester 0 has a complete packet ready; held until done0_o/err0_o/abort0_o
- len0_i  in  16  requester 0 payload length in bytes; stable while req0_i is high
- data0_i  in  8  requester 0 next payload byte (first-word-fall-through)
- rd0_o  out  1  pop strobe to requester 0; data0_i is consumed this cycle
- grant0_o  out  1  requester 0 owns the FIFO
- done0_o  out  1  one-cycle pulse: packet fully written
- err0_o  out  1  one-cycle pulse: length rejected
- abort0_o  out  1  one-cycle pulse: packet lost to tx_reset_i
- req1_i, len1_i, data1_i, rd1_o, grant1_o, done1_o, err1_o, abort1_o: identical set for requester 1
- tx_data_o  out  8  byte to the TX FIFO
- tx_wr_en_o  out  1  TX FIFO write strobe
- tx_full_i  in  1  TX FIFO full
- tx_reset_i  in  1  TX FIFO reset / content lost

Behaviour:
- Clock/reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values: state IDLE, all grant/pulse/strobe outputs 0, tx_data_o 0, priority pointer set so requester 0 wins first, byte counter 0.
- States: IDLE, CHECK, HDR_HI, HDR_LO, DATA, FINISH.
- IDLE:
  - If tx_reset_i=1: no grant; remain IDLE.
  - Otherwise, if any req is high: pick a winner and register its grant (grant high from the next cycle); latch its length into a 16-bit len_q; go to CHECK.
  - Round-robin: if both requesters are requesting, the one not served last wins. The pointer updates only when a grant is issued.
- CHECK (one cycle):
  - If len_q==0 or len_q>MAX_LEN: pulse err for the winner, drop grant, go to IDLE. Nothing is written to the FIFO.
  - Otherwise go to HDR_HI.
- Write rule in HDR_HI, HDR_LO and DATA:
  - tx_wr_en_o = !tx_full_i && !tx_reset_i. This is combinational, with no registered latency.
  - The state or counter advances only in a cycle where tx_wr_en_o=1. Otherwise the state holds and tx_data_o holds its mux value.
- HDR_HI: tx_data_o = len_q[15:8]; on write go to HDR_LO.
- HDR_LO: tx_data_o = len_q[7:0]; on write go to DATA with byte counter = len_q.
- DATA:
  - tx_data_o = the granted requester's data_i; its rd strobe = tx_wr_en_o. The other requester's rd strobe stays 0.
  - Counter decrements on each write. When the write occurs at counter==1, go to FINISH.
- FINISH (one cycle): pulse done for the granted requester; drop grant; go to IDLE. A new arbitration can occur the cycle after FINISH.
- Minimum occupancy per packet: 1 (IDLE) + 1 (CHECK) + 2 (header) + len + 1 (FINISH) cycles.
- tx_reset_i asserted in CHECK/HDR_HI/HDR_LO/DATA:
  - No write that cycle.
  - Pulse abort for the granted requester; drop grant; go to IDLE.
  - The requester must discard its partially popped packet.
- tx_reset_i asserted in FINISH: done is still pulsed (the packet was fully written), and the arbiter returns to IDLE.
- Requester rules:
  - A requester may keep req high after done to queue the next packet; it is re-arbitrated normally.
  - A req deasserted while granted is ignored until the packet ends.
- Widths:
  - Lengths are unsigned 16 bit; the counter is 16 bit.
  - MAX_LEN is compared unsigned; length 65535 is rejected under the default.
- Exclusivity invariants:
  - At most one grant is high at a time.
  - rd0_o and rd1_o are never both high.
  - Any rd strobe implies tx_wr_en_o.

Test Plan:
- Reset/idle: hold rst_i 3 cycles with req0_i=1 -> all outputs 0; after release, grant0_o=1 on the 2nd cycle.
- Single packet: req0 with len0=3, data AA,BB,CC, tx_full_i=0 -> tx FIFO receives 00,03,AA,BB,CC on consecutive cycles; rd0_o high exactly 3 cycles; done0_o pulses once.
- Backpressure: same packet with tx_full_i high for 4 cycles during DATA after byte AA -> no tx_wr_en_o while full; byte sequence unchanged; total 5 writes.
- Round-robin: req0 and req1 both held, len=2 each, for 3 packets each -> grant order 0,1,0,1,0,1; FIFO bytes never interleave between packets.
- Illegal length: len1=0, then len1=1515 -> err1_o pulses each time; zero tx_wr_en_o cycles; req0 is still served afterwards.
- Abort: len0=100, tx_reset_i pulsed after 10 payload bytes -> abort0_o pulse; no done0_o; no write during the reset cycle; next req1 packet starts with its header bytes.

Source files
------------

// File: rtl/eth_tx_arbiter.sv
// Two-requester round-robin scheduler for the byte-wide Ethernet TX FIFO.
// Each granted packet is written as a 16-bit length header (MSB first) followed by its payload.
module eth_tx_arbiter #(
  parameter int unsigned MAX_LEN = 1514
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic [15:0] len0_i,
  input  logic [7:0]  data0_i,
  output logic        rd0_o,
  output logic        grant0_o,
  output logic        done0_o,
  output logic        err0_o,
  output logic        abort0_o,
  input  logic        req1_i,
  input  logic [15:0] len1_i,
  input  logic [7:0]  data1_i,
  output logic        rd1_o,
  output logic        grant1_o,
  output logic        done1_o,
  output logic        err1_o,
  output logic        abort1_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_en_o,
  input  logic        tx_full_i,
  input  logic        tx_reset_i
);

  typedef enum logic [2:0] {IDLE, CHECK, HDR_HI, HDR_LO, DATA, FINISH} state_t;

  localparam logic [15:0] MaxLen = 16'(MAX_LEN);

  state_t      state_q;
  logic [1:0]  grant_q;
  logic        last_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic        done_q;
  logic        err_q;

  logic        pick1;
  logic [15:0] win_len;
  logic        in_write;
  logic        wr_en;
  logic        abort;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick1     = req1_i && (!req0_i || !last_q);
    win_len   = pick1 ? len1_i : len0_i;
    in_write  = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == DATA);
    wr_en     = in_write && !tx_full_i && !tx_reset_i;
    // A rejected packet already reports err during CHECK, so it never also aborts.
    abort     = tx_reset_i && (in_write || (state_q == CHECK && !err_q));
    tx_data_o = '0;
    case (state_q)
      HDR_HI:  tx_data_o = len_q[15:8];
      HDR_LO:  tx_data_o = len_q[7:0];
      DATA:    tx_data_o = grant_q[1] ? data1_i : data0_i;
      default: tx_data_o = '0;
    endcase
  end

  // Completion pulses are all visible while the grant is still high.
  assign tx_wr_en_o = wr_en;
  assign grant0_o   = grant_q[0];
  assign grant1_o   = grant_q[1];
  assign rd0_o      = wr_en && (state_q == DATA) && grant_q[0];
  assign rd1_o      = wr_en && (state_q == DATA) && grant_q[1];
  assign done0_o    = done_q && grant_q[0];
  assign done1_o    = done_q && grant_q[1];
  assign err0_o     = err_q && grant_q[0];
  assign err1_o     = err_q && grant_q[1];
  assign abort0_o   = abort && grant_q[0];
  assign abort1_o   = abort && grant_q[1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!tx_reset_i && (req0_i || req1_i)) begin
            grant_q <= pick1 ? 2'b10 : 2'b01;
            last_q  <= pick1;
            len_q   <= win_len;
            err_q   <= (win_len == '0) || (win_len > MaxLen);
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (err_q || tx_reset_i) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else begin
            state_q <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (tx_reset_i) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (wr_en) begin
            state_q <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (tx_reset_i) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (wr_en) begin
            cnt_q   <= len_q;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (tx_reset_i) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (wr_en) begin
            cnt_q <= cnt_q - 16'd1;
            if (cnt_q == 16'd1) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        FINISH: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: two FWFT requester agents, a packet-level round-robin model
// and one negedge compare process checking the FIFO stream, grants, pulses and invariants.
module tb_eth_tx_arbiter;

  localparam int MAX_LEN = 1514;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_i, req1_i;
  logic [15:0] len0_i, len1_i;
  logic [7:0]  data0_i, data1_i;
  logic        rd0_o, grant0_o, done0_o, err0_o, abort0_o;
  logic        rd1_o, grant1_o, done1_o, err1_o, abort1_o;
  logic [7:0]  tx_data_o;
  logic        tx_wr_en_o;
  logic        tx_full_i;
  logic        tx_reset_i;

  always #5 clk_i = ~clk_i;

  eth_tx_arbiter #(.MAX_LEN(MAX_LEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .len0_i(len0_i), .data0_i(data0_i), .rd0_o(rd0_o), .grant0_o(grant0_o),
    .done0_o(done0_o), .err0_o(err0_o), .abort0_o(abort0_o),
    .req1_i(req1_i), .len1_i(len1_i), .data1_i(data1_i), .rd1_o(rd1_o), .grant1_o(grant1_o),
    .done1_o(done1_o), .err1_o(err1_o), .abort1_o(abort1_o),
    .tx_data_o(tx_data_o), .tx_wr_en_o(tx_wr_en_o), .tx_full_i(tx_full_i), .tx_reset_i(tx_reset_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pay(input logic [7:0] base, input int k);
    return base + 8'(k * 17);
  endfunction

  function automatic bit legal(input int len);
    return (len >= 1) && (len <= MAX_LEN);
  endfunction

  // Requester agents: pending packet lengths and the concatenated payload bytes.
  int         a_len0[$], a_len1[$];
  logic [7:0] a_dat0[$], a_dat1[$];
  int         popped0 = 0, popped1 = 0;
  int         app_pop0 = 0, app_pop1 = 0, app_ret0 = 0, app_ret1 = 0;

  // Packet-level model: expected FIFO stream, grant order and pulse order.
  int         m_len0[$], m_len1[$];
  logic [7:0] m_base0[$], m_base1[$];
  logic       m_last = 1'b1;
  logic [7:0] exp_wr[$];
  int         exp_grant[$];
  int         exp_evt[$];   // code = kind*2 + requester; kind 0 done, 1 err, 2 abort

  // Everything below is written only by the compare process.
  int         cyc = 0;
  logic       g0_prev = 1'b0, g1_prev = 1'b0;
  logic [5:0] ev;
  int         wr_idx = 0, gr_idx = 0, ev_idx = 0;
  logic [7:0] wr_bytes[$];
  int         wr_cyc[$], gr_who[$], gr_cyc[$], done_cyc[$];
  int         n_rd0 = 0, n_err1 = 0, n_abort0 = 0;
  int         mon_pop0 = 0, mon_pop1 = 0, mon_ret0 = 0, mon_ret1 = 0;
  int         mon_kind0 = 0, mon_kind1 = 0;

  task automatic note_grant(input int r);
    gr_who.push_back(r);
    gr_cyc.push_back(cyc);
    if (gr_idx < exp_grant.size()) begin
      check("grant_order", 32'(r), 32'(exp_grant[gr_idx]));
      gr_idx++;
    end else begin
      check("grant_count", 32'(gr_idx + 1), 32'(exp_grant.size()));
    end
  endtask

  always @(negedge clk_i) begin
    cyc++;
    ev = {abort1_o, abort0_o, err1_o, err0_o, done1_o, done0_o};
    if (!rst_i) begin
      check("one_grant", 32'(grant0_o & grant1_o), 32'd0);
      check("one_rd", 32'(rd0_o & rd1_o), 32'd0);
      check("rd_needs_wr", 32'((rd0_o | rd1_o) & ~tx_wr_en_o), 32'd0);
      check("wr_while_blocked", 32'(tx_wr_en_o & (tx_full_i | tx_reset_i)), 32'd0);
      if (rd0_o) begin
        check("rd0_granted", 32'(grant0_o), 32'd1);
        mon_pop0++;
        n_rd0++;
      end
      if (rd1_o) begin
        check("rd1_granted", 32'(grant1_o), 32'd1);
        mon_pop1++;
      end
      if (tx_wr_en_o) begin
        wr_bytes.push_back(tx_data_o);
        wr_cyc.push_back(cyc);
        if (wr_idx < exp_wr.size()) begin
          check("wr_byte", 32'(tx_data_o), 32'(exp_wr[wr_idx]));
          wr_idx++;
        end else begin
          check("wr_count", 32'(wr_idx + 1), 32'(exp_wr.size()));
        end
      end
      if (grant0_o && !g0_prev) note_grant(0);
      if (grant1_o && !g1_prev) note_grant(1);
      for (int c = 0; c < 6; c++) begin
        if (ev[c]) begin
          if (ev_idx < exp_evt.size()) begin
            check("event", 32'(c), 32'(exp_evt[ev_idx]));
            ev_idx++;
          end else begin
            check("event_count", 32'(ev_idx + 1), 32'(exp_evt.size()));
          end
          if (c < 2) done_cyc.push_back(cyc);
          if (c == 3) n_err1++;
          if (c == 4) n_abort0++;
          if (c % 2 == 0) begin
            mon_kind0 = c / 2 + 1;
            mon_ret0++;
          end else begin
            mon_kind1 = c / 2 + 1;
            mon_ret1++;
          end
        end
      end
    end
    g0_prev = grant0_o;
    g1_prev = grant1_o;
  end

  task automatic agent_load(input int r, input int len, input logic [7:0] base);
    if (r == 0) begin
      a_len0.push_back(len);
      if (legal(len)) for (int k = 0; k < len; k++) a_dat0.push_back(pay(base, k));
    end else begin
      a_len1.push_back(len);
      if (legal(len)) for (int k = 0; k < len; k++) a_dat1.push_back(pay(base, k));
    end
  endtask

  task automatic load(input int r, input int len, input logic [7:0] base);
    agent_load(r, len, base);
    if (r == 0) begin
      m_len0.push_back(len);
      m_base0.push_back(base);
    end else begin
      m_len1.push_back(len);
      m_base1.push_back(base);
    end
  endtask

  // Serve every queued packet in round-robin order and append its expected outcome.
  task automatic plan();
    int         w;
    int         len;
    logic [7:0] base;
    while (m_len0.size() > 0 || m_len1.size() > 0) begin
      if (m_len0.size() > 0 && m_len1.size() > 0) w = m_last ? 0 : 1;
      else w = (m_len0.size() > 0) ? 0 : 1;
      m_last = (w == 1);
      if (w == 0) begin
        len  = m_len0.pop_front();
        base = m_base0.pop_front();
      end else begin
        len  = m_len1.pop_front();
        base = m_base1.pop_front();
      end
      exp_grant.push_back(w);
      if (legal(len)) begin
        exp_wr.push_back(8'(len >> 8));
        exp_wr.push_back(8'(len));
        for (int k = 0; k < len; k++) exp_wr.push_back(pay(base, k));
        exp_evt.push_back(w);
      end else begin
        exp_evt.push_back(2 + w);
      end
    end
  endtask

  task automatic drive();
    req0_i  = a_len0.size() > 0;
    len0_i  = req0_i ? 16'(a_len0[0]) : 16'h0;
    data0_i = (a_dat0.size() > 0) ? a_dat0[0] : 8'h00;
    req1_i  = a_len1.size() > 0;
    len1_i  = req1_i ? 16'(a_len1[0]) : 16'h0;
    data1_i = (a_dat1.size() > 0) ? a_dat1[0] : 8'h00;
  endtask

  // Advance one clock; apply the pops and retirements seen in the cycle that just ended.
  task automatic tick();
    logic [7:0] junk;
    int         dummy;
    @(posedge clk_i);
    #1;
    while (app_pop0 < mon_pop0) begin
      if (a_dat0.size() > 0) junk = a_dat0.pop_front();
      popped0++;
      app_pop0++;
    end
    while (app_pop1 < mon_pop1) begin
      if (a_dat1.size() > 0) junk = a_dat1.pop_front();
      popped1++;
      app_pop1++;
    end
    if (app_ret0 < mon_ret0) begin
      if (mon_kind0 == 1) check("pops_per_packet0", 32'(popped0), 32'(a_len0[0]));
      if (mon_kind0 == 3)
        while (popped0 < a_len0[0] && a_dat0.size() > 0) begin
          junk = a_dat0.pop_front();
          popped0++;
        end
      if (a_len0.size() > 0) dummy = a_len0.pop_front();
      popped0 = 0;
      app_ret0++;
    end
    if (app_ret1 < mon_ret1) begin
      if (mon_kind1 == 1) check("pops_per_packet1", 32'(popped1), 32'(a_len1[0]));
      if (mon_kind1 == 3)
        while (popped1 < a_len1[0] && a_dat1.size() > 0) begin
          junk = a_dat1.pop_front();
          popped1++;
        end
      if (a_len1.size() > 0) dummy = a_len1.pop_front();
      popped1 = 0;
      app_ret1++;
    end
    drive();
  endtask

  task automatic run_idle(input int max_cyc);
    int n = 0;
    while ((a_len0.size() > 0 || a_len1.size() > 0 || grant0_o || grant1_o) && n < max_cyc) begin
      tick();
      n++;
    end
    check("run_in_budget", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic wait_writes(input int wb, input int count);
    int n = 0;
    while (wr_bytes.size() - wb < count && n < 400) begin
      tick();
      n++;
    end
    check("writes_reached", 32'(wr_bytes.size() - wb), 32'(count));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         wb, gb, db, rb, eb, ab;
    logic [7:0] lit_single[5];
    int         lit_rr[6];
    int         lit_ill[3];
    lit_single = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    lit_rr     = '{0, 1, 0, 1, 0, 1};
    lit_ill    = '{1, 0, 1};

    rst_i = 1'b1;
    tx_full_i = 1'b0;
    tx_reset_i = 1'b0;

    // Reset with req0 already pending, then the single-packet case.
    load(0, 3, 8'hAA);
    plan();
    drive();
    repeat (3) begin
      @(negedge clk_i);
      check("reset_outputs_zero", 32'({grant0_o, grant1_o, rd0_o, rd1_o, done0_o, done1_o, err0_o,
            err1_o, abort0_o, abort1_o, tx_wr_en_o, tx_data_o}), 32'd0);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("grant0_cycle1_low", 32'(grant0_o), 32'd0);
    tick();
    @(negedge clk_i);
    check("grant0_cycle2_high", 32'(grant0_o), 32'd1);
    run_idle(100);
    check("single_nwr", 32'(wr_bytes.size()), 32'd5);
    for (int k = 0; k < 5; k++) check("single_byte", 32'(wr_bytes[k]), 32'(lit_single[k]));
    check("single_back_to_back", 32'(wr_cyc[4] - wr_cyc[0]), 32'd4);
    check("single_rd0_cycles", 32'(n_rd0), 32'd3);
    check("single_done_count", 32'(done_cyc.size()), 32'd1);
    check("single_occupancy", 32'(done_cyc[0] - gr_cyc[0]), 32'd6);

    // Backpressure: FIFO full for four cycles right after byte AA.
    wb = wr_bytes.size();
    load(0, 3, 8'hAA);
    plan();
    drive();
    wait_writes(wb, 3);
    tx_full_i = 1'b1;
    repeat (4) tick();
    tx_full_i = 1'b0;
    run_idle(100);
    check("bp_nwr", 32'(wr_bytes.size() - wb), 32'd5);
    for (int k = 0; k < 5; k++) check("bp_byte", 32'(wr_bytes[wb + k]), 32'(lit_single[k]));
    check("bp_stall_gap", 32'(wr_cyc[wb + 3] - wr_cyc[wb + 2]), 32'd5);

    // Illegal lengths on requester 1 with requester 0 also waiting.
    wb = wr_bytes.size();
    gb = gr_who.size();
    eb = n_err1;
    load(1, 0, 8'h00);
    load(1, 1515, 8'h00);
    load(0, 2, 8'h50);
    plan();
    drive();
    run_idle(200);
    check("ill_err1_pulses", 32'(n_err1 - eb), 32'd2);
    check("ill_nwr", 32'(wr_bytes.size() - wb), 32'd4);
    for (int k = 0; k < 3; k++) check("ill_grant_order", 32'(gr_who[gb + k]), 32'(lit_ill[k]));

    // Round-robin: three packets each, both requests held throughout.
    wb = wr_bytes.size();
    gb = gr_who.size();
    for (int i = 0; i < 3; i++) begin
      load(0, 2, 8'(8'h01 + 8'(i * 4)));
      load(1, 2, 8'(8'h81 + 8'(i * 4)));
    end
    plan();
    drive();
    run_idle(300);
    for (int k = 0; k < 6; k++) check("rr_grant_order", 32'(gr_who[gb + k]), 32'(lit_rr[k]));
    check("rr_rearbitrate_gap", 32'(gr_cyc[gb + 1] - gr_cyc[gb]), 32'd7);
    check("rr_nwr", 32'(wr_bytes.size() - wb), 32'd24);

    // Abort after ten payload bytes, then a requester-1 packet.
    wb = wr_bytes.size();
    db = done_cyc.size();
    ab = n_abort0;
    agent_load(0, 100, 8'h10);
    exp_grant.push_back(0);
    exp_wr.push_back(8'h00);
    exp_wr.push_back(8'h64);
    for (int k = 0; k < 10; k++) exp_wr.push_back(pay(8'h10, k));
    exp_evt.push_back(4);
    m_last = 1'b0;
    drive();
    wait_writes(wb, 12);
    tx_reset_i = 1'b1;
    tick();
    tx_reset_i = 1'b0;
    check("abort_pulse", 32'(n_abort0 - ab), 32'd1);
    check("abort_no_done", 32'(done_cyc.size() - db), 32'd0);
    check("abort_no_write", 32'(wr_bytes.size() - wb), 32'd12);
    check("abort_discarded", 32'(a_dat0.size()), 32'd0);
    load(1, 4, 8'h70);
    plan();
    drive();
    run_idle(100);
    check("abort_next_hdr_hi", 32'(wr_bytes[wb + 12]), 32'h00);
    check("abort_next_hdr_lo", 32'(wr_bytes[wb + 13]), 32'h04);
    check("abort_nwr", 32'(wr_bytes.size() - wb), 32'd18);

    // Length boundaries: MAX_LEN accepted, 65535 rejected, 1 accepted.
    wb = wr_bytes.size();
    eb = n_err1;
    load(0, MAX_LEN, 8'h00);
    load(1, 65535, 8'h00);
    load(0, 1, 8'h33);
    plan();
    drive();
    run_idle(4000);
    check("bound_hdr_hi", 32'(wr_bytes[wb]), 32'h05);
    check("bound_hdr_lo", 32'(wr_bytes[wb + 1]), 32'hEA);
    check("bound_err1", 32'(n_err1 - eb), 32'd1);
    check("bound_nwr", 32'(wr_bytes.size() - wb), 32'd1519);

    check("all_bytes_seen", 32'(wr_idx), 32'(exp_wr.size()));
    check("all_grants_seen", 32'(gr_idx), 32'(exp_grant.size()));
    check("all_events_seen", 32'(ev_idx), 32'(exp_evt.size()));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
